// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the MPEG-2 TS sync recovery stage.
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_LEN_188   = 188;
  localparam int         TS_LEN_204   = 204;

  typedef logic [1:0] ts_state_t;

  localparam ts_state_t HUNT     = 2'd0;
  localparam ts_state_t VERIFY   = 2'd1;
  localparam ts_state_t LOCKED   = 2'd2;
  localparam ts_state_t FLYWHEEL = 2'd3;

endpackage

// File: rtl/ts_sync_lock_if.sv
// Byte-stream bus into the sync recovery stage and its aligned, annotated output.
interface ts_sync_lock_if #(
  parameter int LOSS_CNT_W = 16
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  pkt_len_sel;
  logic [7:0]            byte_out;
  logic                  valid;
  logic                  sync;
  logic                  locked;
  logic                  sync_loss;
  logic [LOSS_CNT_W-1:0] loss_cnt;

  modport master (
    output byte_in, byte_valid, pkt_len_sel,
    input  byte_out, valid, sync, locked, sync_loss, loss_cnt
  );

  modport slave (
    input  byte_in, byte_valid, pkt_len_sel,
    output byte_out, valid, sync, locked, sync_loss, loss_cnt
  );
endinterface

// File: rtl/ts_pos_counter.sv
// Packet position counter: wraps from len-1 to 0, can be forced to 1 on a new candidate.
module ts_pos_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] len,
  input  logic         adv,
  input  logic         load1,
  output logic [W-1:0] pos
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    if (!rst) begin
      pos <= '0;
    end else if (load1) begin
      pos <= W'(1);
    end else if (adv) begin
      pos <= (pos == len - W'(1)) ? '0 : pos + W'(1);
    end
  end

endmodule

// File: rtl/ts_sync_lock.sv
// TS sync hunter/verifier with flywheel lock holding and a saturating lock-loss counter.
module ts_sync_lock
  import ts_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int         PKT_LEN_A  = TS_LEN_188,
  parameter int         PKT_LEN_B  = TS_LEN_204,
  parameter int         LOCK_CNT   = 5,
  parameter int         UNLOCK_CNT = 3,
  parameter int         LOSS_CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  ts_sync_lock_if.slave  bus
);

  localparam int         POS_W    = $clog2((PKT_LEN_A > PKT_LEN_B) ? PKT_LEN_A : PKT_LEN_B);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

  ts_state_t        state_q, state_d;
  logic [3:0]       hits_q, hits_d;
  logic [3:0]       miss_q, miss_d;
  logic [POS_W-1:0] len_q, len_d;
  logic [POS_W-1:0] pos;
  logic             adv, load1;
  logic             sync_d, loss_d, locked_d;

  logic [7:0]            byte_out_q;
  logic                  valid_q, sync_q, locked_q, sync_loss_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  logic is_sync, at0;
  assign is_sync = (bus.byte_in == SYNC_BYTE);
  assign at0     = (pos == '0);

  ts_pos_counter #(.W(POS_W)) u_pos (
    .clk   (clk),
    .rst   (rst),
    .len   (len_q),
    .adv   (adv),
    .load1 (load1),
    .pos   (pos)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    len_d    = len_q;
    adv      = 1'b0;
    load1    = 1'b0;
    sync_d   = 1'b0;
    loss_d   = 1'b0;
    locked_d = locked_q;

    if (bus.byte_valid) begin
      case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d = VERIFY;
            hits_d  = 4'd1;
            load1   = 1'b1;
            len_d   = bus.pkt_len_sel ? POS_W'(PKT_LEN_B) : POS_W'(PKT_LEN_A);
          end
        end
        VERIFY: begin
          adv = 1'b1;
          if (at0) begin
            if (!is_sync) begin
              state_d = HUNT;
            end else if (hits_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
              sync_d  = 1'b1;
            end else begin
              hits_d = hits_q + 4'd1;
            end
          end
        end
        LOCKED: begin
          adv = 1'b1;
          if (at0) begin
            sync_d = 1'b1;
            if (is_sync) begin
              miss_d = '0;
            end else if (UNLOCK_N == 4'd1) begin
              state_d = HUNT;
              sync_d  = 1'b0;
              loss_d  = 1'b1;
            end else begin
              state_d = FLYWHEEL;
              miss_d  = 4'd1;
            end
          end
        end
        FLYWHEEL: begin
          adv = 1'b1;
          if (at0) begin
            if (is_sync) begin
              state_d = LOCKED;
              miss_d  = '0;
              sync_d  = 1'b1;
            end else if (miss_q + 4'd1 < UNLOCK_N) begin
              miss_d = miss_q + 4'd1;
              sync_d = 1'b1;
            end else begin
              state_d = HUNT;
              loss_d  = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
      locked_d = (state_d == LOCKED) || (state_d == FLYWHEEL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HUNT;
      hits_q      <= '0;
      miss_q      <= '0;
      len_q       <= '0;
      byte_out_q  <= '0;
      valid_q     <= 1'b0;
      sync_q      <= 1'b0;
      locked_q    <= 1'b0;
      sync_loss_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hits_q      <= hits_d;
      miss_q      <= miss_d;
      len_q       <= len_d;
      byte_out_q  <= bus.byte_valid ? bus.byte_in : 8'h00;
      valid_q     <= bus.byte_valid;
      sync_q      <= sync_d;
      locked_q    <= locked_d;
      sync_loss_q <= loss_d;
      if (loss_d && (loss_cnt_q != '1)) begin
        loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
      end
    end
  end

  assign bus.byte_out  = byte_out_q;
  assign bus.valid     = valid_q;
  assign bus.sync      = sync_q;
  assign bus.locked    = locked_q;
  assign bus.sync_loss = sync_loss_q;
  assign bus.loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_ts_sync_lock.sv
// Directed bench for ts_sync_lock: acquisition, flywheel, loss, 204 mode, gaps, reset, false sync.
module tb_ts_sync_lock;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   byte_idx = 0;
  logic last_locked = 1'b0;

  always #5 clk = ~clk;

  ts_sync_lock_if #(.LOSS_CNT_W(16)) bus ();

  ts_sync_lock #(
    .SYNC_BYTE  (8'h47),
    .PKT_LEN_A  (188),
    .PKT_LEN_B  (204),
    .LOCK_CNT   (5),
    .UNLOCK_CNT (3),
    .LOSS_CNT_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
    @(posedge clk);
    #1;
    chk($sformatf("gap%0d valid", byte_idx), 32'(bus.valid), 32'd0);
    chk($sformatf("gap%0d byte_out", byte_idx), 32'(bus.byte_out), 32'd0);
    chk($sformatf("gap%0d sync", byte_idx), 32'(bus.sync), 32'd0);
    chk($sformatf("gap%0d sync_loss", byte_idx), 32'(bus.sync_loss), 32'd0);
    chk($sformatf("gap%0d locked", byte_idx), 32'(bus.locked), 32'(last_locked));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit es, input bit elk, input bit eloss,
                           input bit gaps);
    if (gaps && ($urandom_range(7) == 0)) begin
      repeat ($urandom_range(4, 1)) idle_cycle();
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    @(posedge clk);
    #1;
    chk($sformatf("b%0d valid", byte_idx), 32'(bus.valid), 32'd1);
    chk($sformatf("b%0d byte_out", byte_idx), 32'(bus.byte_out), 32'(b));
    chk($sformatf("b%0d sync", byte_idx), 32'(bus.sync), 32'(es));
    chk($sformatf("b%0d locked", byte_idx), 32'(bus.locked), 32'(elk));
    chk($sformatf("b%0d sync_loss", byte_idx), 32'(bus.sync_loss), 32'(eloss));
    last_locked = elk;
    byte_idx++;
  endtask

  // Sends packet bytes first..n_end-1; byte 0 carries sb, false_off (if >0) carries a stray 8'h47.
  task automatic send_pkt(input int n_end, input int first, input logic [7:0] sb,
                          input bit es, input bit elk, input bit eloss,
                          input int false_off, input bit gaps);
    logic [7:0] b;
    for (int i = first; i < n_end; i++) begin
      if (i == 0)              b = sb;
      else if (i == false_off) b = 8'h47;
      else                     b = {2'b10, 6'(i)};
      send_byte(b, (i == 0) ? es : 1'b0, elk, (i == 0) ? eloss : 1'b0, gaps);
    end
  endtask

  task automatic acquire(input int len, input bit gaps);
    for (int p = 0; p < 4; p++) send_pkt(len, 0, 8'h47, 1'b0, 1'b0, 1'b0, -1, gaps);
    send_pkt(len, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, gaps);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst            = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h47;
    @(posedge clk);
    #1;
    chk({tag, " valid"}, 32'(bus.valid), 32'd0);
    chk({tag, " byte_out"}, 32'(bus.byte_out), 32'd0);
    chk({tag, " sync"}, 32'(bus.sync), 32'd0);
    chk({tag, " locked"}, 32'(bus.locked), 32'd0);
    chk({tag, " sync_loss"}, 32'(bus.sync_loss), 32'd0);
    chk({tag, " loss_cnt"}, 32'(bus.loss_cnt), 32'd0);
    @(negedge clk);
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    last_locked    = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.pkt_len_sel = 1'b0;

    do_reset("rst0");

    // Acquisition on 188-byte packets: sync first appears with input byte 752.
    acquire(188, 1'b0);
    send_pkt(188, 0, 8'h47, 1'b1, 1'b1, 1'b0, 50, 1'b0);

    // Single corrupted sync, then alternating corruption within the flywheel budget.
    send_pkt(188, 0, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h12, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    chk("loss_cnt after flywheel", 32'(bus.loss_cnt), 32'd0);

    // Three consecutive misses drop lock on the third.
    send_pkt(188, 0, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(188, 0, 8'h00, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    chk("loss_cnt after loss", 32'(bus.loss_cnt), 32'd1);

    // Relock needs five fresh good syncs.
    acquire(188, 1'b0);
    chk("loss_cnt after relock", 32'(bus.loss_cnt), 32'd1);

    // Reset in the middle of a locked packet.
    send_pkt(100, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    do_reset("rst_locked");

    // False candidate at offset 10 is rejected one packet later; lock follows the true alignment.
    send_pkt(188, 1, 8'h47, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    send_pkt(188, 0, 8'h47, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    acquire(188, 1'b0);

    // 204-byte mode; pkt_len_sel changes while locked are ignored.
    do_reset("rst_204");
    bus.pkt_len_sel = 1'b1;
    acquire(204, 1'b0);
    bus.pkt_len_sel = 1'b0;
    send_pkt(204, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(204, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b0);

    // Random idle gaps: the sequence indexed by valid bytes is unchanged.
    do_reset("rst_gaps");
    acquire(188, 1'b1);
    send_pkt(188, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b1);
    send_pkt(188, 0, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b1);
    send_pkt(188, 0, 8'h47, 1'b1, 1'b1, 1'b0, -1, 1'b1);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
